// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared FSM encoding, frame size, seg7 codes and BCD helper
package dino_pkg;

    localparam int FRAME_BITS = 64;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } seg_state_e;

    // Active-low {dp,g,f,e,d,c,b,a}, decimal point always off
    localparam logic [7:0] SEG7_0     = 8'hC0;
    localparam logic [7:0] SEG7_1     = 8'hF9;
    localparam logic [7:0] SEG7_2     = 8'hA4;
    localparam logic [7:0] SEG7_3     = 8'hB0;
    localparam logic [7:0] SEG7_4     = 8'h99;
    localparam logic [7:0] SEG7_5     = 8'h92;
    localparam logic [7:0] SEG7_6     = 8'h82;
    localparam logic [7:0] SEG7_7     = 8'hF8;
    localparam logic [7:0] SEG7_8     = 8'h80;
    localparam logic [7:0] SEG7_9     = 8'h90;
    localparam logic [7:0] SEG7_BLANK = 8'hFF;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[i*4 +: 4] >= 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/score_segled_if.sv
// rtl/score_segled_if.sv - serial bus to the 74HC164 segment chain
interface score_segled_if;
    logic seg_clk;
    logic seg_do;
    logic seg_pen;
    logic seg_clr;

    modport master (output seg_clk, output seg_do, output seg_pen, output seg_clr);
    modport slave  (input  seg_clk, input  seg_do, input  seg_pen, input  seg_clr);
endinterface

// File: rtl/seg7_enc.sv
// rtl/seg7_enc.sv - BCD digit to active-low seven-segment byte
module seg7_enc
    import dino_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG7_BLANK;
        case (digit_i)
            4'd0: seg_o = SEG7_0;
            4'd1: seg_o = SEG7_1;
            4'd2: seg_o = SEG7_2;
            4'd3: seg_o = SEG7_3;
            4'd4: seg_o = SEG7_4;
            4'd5: seg_o = SEG7_5;
            4'd6: seg_o = SEG7_6;
            4'd7: seg_o = SEG7_7;
            4'd8: seg_o = SEG7_8;
            4'd9: seg_o = SEG7_9;
            default: seg_o = SEG7_BLANK;
        endcase
    end

endmodule

// File: rtl/score_segled.sv
// rtl/score_segled.sv - BCD score/hi-score keeper driving a serial 7-seg chain
module score_segled
    import dino_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        tick,
    input  logic        run,
    input  logic        clear,
    output logic [15:0] score,
    output logic [15:0] hi_score,
    output logic        seg_clk,
    output logic        seg_do,
    output logic        seg_pen,
    output logic        seg_clr,
    output logic        busy
);

    localparam logic [7:0]       DIV_M1   = 8'(DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

    seg_state_e            state_q, state_d;
    logic [15:0]           score_q, score_d;
    logic [15:0]           hi_q, hi_d;
    logic                  run_q;
    logic                  pending_q, pending_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [7:0]            div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  seg_clk_q, seg_clk_d;
    logic                  seg_clr_q;

    logic [31:0]           digits;
    logic [FRAME_BITS-1:0] frame;
    logic                  last_edge;

    // Byte order: hi_score digit 3 is the top byte and shifts out first
    assign digits = {hi_q, score_q};

    for (genvar g = 0; g < 8; g++) begin : g_enc
        seg7_enc u_enc (
            .digit_i (digits[g*4 +: 4]),
            .seg_o   (frame[g*8 +: 8])
        );
    end

    always_comb begin
        score_d = score_q;
        if (clear) begin
            score_d = 16'h0000;
        end else if (tick && run) begin
            score_d = bcd_inc(score_q);
        end
    end

    always_comb begin
        hi_d = hi_q;
        if (run_q && !run && (score_q > hi_q)) begin
            hi_d = score_q;
        end
    end

    // A change on the same edge as entering LOAD keeps pending set for another frame
    always_comb begin
        pending_d = pending_q;
        if (state_q == ST_IDLE && pending_q) begin
            pending_d = 1'b0;
        end
        if (score_d != score_q || hi_d != hi_q) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            score_q   <= 16'h0000;
            hi_q      <= 16'h0000;
            run_q     <= 1'b0;
            pending_q <= 1'b1;
            seg_clr_q <= 1'b0;
        end else begin
            score_q   <= score_d;
            hi_q      <= hi_d;
            run_q     <= run;
            pending_q <= pending_d;
            seg_clr_q <= 1'b1;
        end
    end

    assign last_edge = (div_q == DIV_M1) && seg_clk_q && (bit_q == LAST_BIT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pending_q) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (last_edge) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Data changes on the falling seg_clk edge so it is stable at the 164's rising edge
    always_comb begin
        shreg_d   = shreg_q;
        div_d     = div_q;
        bit_d     = bit_q;
        seg_clk_d = seg_clk_q;
        case (state_q)
            ST_LOAD: begin
                shreg_d   = frame;
                div_d     = 8'd0;
                bit_d     = '0;
                seg_clk_d = 1'b0;
            end
            ST_SHIFT: begin
                if (div_q == DIV_M1) begin
                    div_d     = 8'd0;
                    seg_clk_d = !seg_clk_q;
                    if (seg_clk_q) begin
                        shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_LATCH: seg_clk_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg_q   <= '0;
            div_q     <= 8'd0;
            bit_q     <= '0;
            seg_clk_q <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            seg_clk_q <= seg_clk_d;
        end
    end

    always_comb begin
        seg_pen  = (state_q == ST_IDLE);
        busy     = (state_q != ST_IDLE);
        seg_clk  = seg_clk_q;
        seg_do   = shreg_q[FRAME_BITS-1];
        seg_clr  = seg_clr_q;
        score    = score_q;
        hi_score = hi_q;
    end

endmodule

// File: tb/tb_score_segled.sv
// tb/tb_score_segled.sv - directed self-checking bench for score_segled
module tb_score_segled;

    localparam int DIV       = 4;
    localparam int FRAME_CYC = 2 + 128 * DIV;
    localparam logic [63:0] ALL_ZERO = 64'hC0C0_C0C0_C0C0_C0C0;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        tick = 1'b0;
    logic        run = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] score;
    logic [15:0] hi_score;
    logic        busy;

    score_segled_if seg_bus ();

    score_segled #(.DIV(DIV)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .tick     (tick),
        .run      (run),
        .clear    (clear),
        .score    (score),
        .hi_score (hi_score),
        .seg_clk  (seg_bus.seg_clk),
        .seg_do   (seg_bus.seg_do),
        .seg_pen  (seg_bus.seg_pen),
        .seg_clr  (seg_bus.seg_clr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] cap_sr = '0;
    logic [63:0] last_frame = '0;
    int cap_bits = 0, last_bits = 0, pen_cnt = 0, last_pen = 0;
    int gap_cnt = 0, last_gap = -1, frames = 0;
    logic prev_clk = 1'b0, prev_pen = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                cap_bits = 0;
                pen_cnt  = 0;
                gap_cnt  = 0;
                prev_clk = 1'b0;
                prev_pen = 1'b1;
            end else begin
                if (!seg_bus.seg_pen) begin
                    if (prev_pen) begin
                        last_gap = gap_cnt;
                        cap_bits = 0;
                        pen_cnt  = 0;
                        cap_sr   = '0;
                    end
                    pen_cnt++;
                    if (seg_bus.seg_clk && !prev_clk) begin
                        cap_sr = {cap_sr[62:0], seg_bus.seg_do};
                        cap_bits++;
                    end
                end else begin
                    if (!prev_pen) begin
                        last_frame = cap_sr;
                        last_bits  = cap_bits;
                        last_pen   = pen_cnt;
                        frames++;
                        gap_cnt    = 0;
                    end
                    gap_cnt++;
                end
                prev_clk = seg_bus.seg_clk;
                prev_pen = seg_bus.seg_pen;
            end
        end
    end

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] frame_of(input logic [15:0] hi, input logic [15:0] sc);
        return {seg_of(hi[15:12]), seg_of(hi[11:8]), seg_of(hi[7:4]), seg_of(hi[3:0]),
                seg_of(sc[15:12]), seg_of(sc[11:8]), seg_of(sc[7:4]), seg_of(sc[3:0])};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic wait_quiet();
        int idle = 0;
        int t = 0;
        while (idle < 4 && t < 5000) begin
            step();
            t++;
            idle = busy ? 0 : idle + 1;
        end
        vectors++;
        if (idle < 4) begin
            miscompares++;
            $display("FAIL quiet_timeout: busy still toggling after %0d cycles, want idle", t);
        end
    endtask

    task automatic wait_bits(input int n);
        int t = 0;
        while (!(!seg_bus.seg_pen && cap_bits >= n) && t < 3000) begin
            step();
            t++;
        end
        vectors++;
        if (t >= 3000) begin
            miscompares++;
            $display("FAIL bits_timeout: cap_bits=%0d want %0d", cap_bits, n);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) step();
        vectors++;
        if ({score, hi_score} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_scores: got %h want 00000000", {score, hi_score});
        end
        vectors++;
        if ({seg_bus.seg_pen, busy, seg_bus.seg_clr, seg_bus.seg_clk, seg_bus.seg_do} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 10000",
                     {seg_bus.seg_pen, busy, seg_bus.seg_clr, seg_bus.seg_clk, seg_bus.seg_do});
        end
        rstn = 1'b1;
        step();
        vectors++;
        if (seg_bus.seg_clr !== 1'b1) begin
            miscompares++;
            $display("FAIL seg_clr_release: got %b want 1", seg_bus.seg_clr);
        end
        wait_quiet();
        vectors++;
        if (frames !== 1) begin
            miscompares++;
            $display("FAIL reset_frame_count: got %0d want 1", frames);
        end
        vectors++;
        if (last_frame !== ALL_ZERO) begin
            miscompares++;
            $display("FAIL reset_frame: got %h want %h", last_frame, ALL_ZERO);
        end
        vectors++;
        if (last_pen !== FRAME_CYC || last_bits !== 64) begin
            miscompares++;
            $display("FAIL reset_frame_len: pen_low=%0d bits=%0d want %0d/64", last_pen, last_bits, FRAME_CYC);
        end
    endtask

    task automatic test_run_gate();
        run = 1'b0;
        do_ticks(1);
        step();
        vectors++;
        if (score !== 16'h0000) begin
            miscompares++;
            $display("FAIL tick_without_run: got %h want 0000", score);
        end
    endtask

    task automatic test_count();
        run = 1'b1;
        step();
        repeat (3) begin
            do_ticks(1);
            step();
        end
        vectors++;
        if (score !== 16'h0003) begin
            miscompares++;
            $display("FAIL count3: got %h want 0003", score);
        end
        wait_quiet();
        vectors++;
        if (last_frame !== frame_of(16'h0000, 16'h0003) || last_frame[7:0] !== 8'hB0) begin
            miscompares++;
            $display("FAIL count3_frame: got %h want %h", last_frame, frame_of(16'h0000, 16'h0003));
        end
    endtask

    task automatic test_wrap();
        do_ticks(9996);
        vectors++;
        if (score !== 16'h9999) begin
            miscompares++;
            $display("FAIL reach_9999: got %h want 9999", score);
        end
        do_ticks(1);
        vectors++;
        if (score !== 16'h0000 || hi_score !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap: got %h/%h want 0000/0000", score, hi_score);
        end
        wait_quiet();
        vectors++;
        if (last_frame !== ALL_ZERO) begin
            miscompares++;
            $display("FAIL wrap_frame: got %h want %h", last_frame, ALL_ZERO);
        end
    endtask

    task automatic test_clear_tick();
        do_ticks(42);
        vectors++;
        if (score !== 16'h0042) begin
            miscompares++;
            $display("FAIL count42: got %h want 0042", score);
        end
        tick  = 1'b1;
        clear = 1'b1;
        step();
        tick  = 1'b0;
        clear = 1'b0;
        step();
        vectors++;
        if (score !== 16'h0000) begin
            miscompares++;
            $display("FAIL clear_wins: got %h want 0000", score);
        end
    endtask

    task automatic test_hi_score();
        do_ticks(125);
        vectors++;
        if (score !== 16'h0125) begin
            miscompares++;
            $display("FAIL count125: got %h want 0125", score);
        end
        run = 1'b0;
        step();
        step();
        vectors++;
        if (hi_score !== 16'h0125) begin
            miscompares++;
            $display("FAIL hi_set: got %h want 0125", hi_score);
        end
        run   = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        do_ticks(100);
        vectors++;
        if (score !== 16'h0100) begin
            miscompares++;
            $display("FAIL count100: got %h want 0100", score);
        end
        run = 1'b0;
        step();
        step();
        vectors++;
        if (hi_score !== 16'h0125) begin
            miscompares++;
            $display("FAIL hi_kept: got %h want 0125", hi_score);
        end
        wait_quiet();
        vectors++;
        if (last_frame !== frame_of(16'h0125, 16'h0100)) begin
            miscompares++;
            $display("FAIL hi_frame: got %h want %h", last_frame, frame_of(16'h0125, 16'h0100));
        end
    endtask

    task automatic test_mid_frame_tick();
        int f0;
        int t = 0;
        run = 1'b1;
        step();
        f0 = frames;
        do_ticks(1);
        wait_bits(20);
        do_ticks(1);
        while (frames == f0 && t < 3000) begin
            step();
            t++;
        end
        vectors++;
        if (last_frame !== frame_of(16'h0125, 16'h0101) || last_bits !== 64) begin
            miscompares++;
            $display("FAIL mid_frame_bits: got %h (%0d bits) want %h", last_frame, last_bits,
                     frame_of(16'h0125, 16'h0101));
        end
        wait_quiet();
        vectors++;
        if (frames !== f0 + 2 || last_frame !== frame_of(16'h0125, 16'h0102)) begin
            miscompares++;
            $display("FAIL followup_frame: got %h frames=%0d want %h frames=%0d", last_frame, frames,
                     frame_of(16'h0125, 16'h0102), f0 + 2);
        end
        vectors++;
        if (last_gap < 1 || last_gap > 2) begin
            miscompares++;
            $display("FAIL followup_gap: got %0d cycles want 1..2", last_gap);
        end
    endtask

    task automatic test_reset_abort();
        int f0;
        do_ticks(1);
        wait_bits(10);
        rstn = 1'b0;
        #1;
        vectors++;
        if ({seg_bus.seg_pen, busy, seg_bus.seg_clr, seg_bus.seg_clk} !== 4'b1000 ||
            {score, hi_score} !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_reset: pen/busy/clr/clk=%b scores=%h want 1000/00000000",
                     {seg_bus.seg_pen, busy, seg_bus.seg_clr, seg_bus.seg_clk}, {score, hi_score});
        end
        step();
        f0 = frames;
        rstn = 1'b1;
        wait_quiet();
        vectors++;
        if (frames !== f0 + 1 || last_frame !== ALL_ZERO || last_pen !== FRAME_CYC) begin
            miscompares++;
            $display("FAIL abort_refresh: got %h frames=%0d pen=%0d want %h frames=%0d pen=%0d",
                     last_frame, frames, last_pen, ALL_ZERO, f0 + 1, FRAME_CYC);
        end
    endtask

    initial begin
        test_reset();
        test_run_gate();
        test_count();
        test_wrap();
        test_clear_tick();
        test_hi_score();
        test_mid_frame_tick();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
